// File: rtl/hazard_pkg.sv
// Shared types and constants for the pipeline hazard controller.
package hazard_pkg;

  localparam int REG_W = 5;
  localparam logic [REG_W-1:0] REG_ZERO = 5'd0;

  typedef enum logic [0:0] {
    ST_RUN  = 1'b0,
    ST_BUSY = 1'b1
  } md_state_e;

  // True when an enabled source operand names a real (non-$0) destination.
  function automatic logic reg_match(input logic uses,
                                     input logic [REG_W-1:0] src,
                                     input logic [REG_W-1:0] dst);
    return uses && (dst != REG_ZERO) && (dst == src);
  endfunction

endpackage

// File: rtl/hazard_controller_muldiv_tracker.sv
// Occupancy tracker for the multi-cycle mult/div unit: RUN/BUSY FSM
// with a down-counter covering the remaining EX cycles.
module muldiv_tracker
  import hazard_pkg::*;
#(
  parameter int MULDIV_CYCLES = 32
) (
  input  logic clock,
  input  logic reset,
  input  logic accept,
  output logic busy_o
);

  localparam int CW = $clog2(MULDIV_CYCLES);
  localparam logic [CW-1:0] CNT_LOAD = CW'(MULDIV_CYCLES - 1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);
  localparam logic [CW-1:0] CNT_ZERO = CW'(0);

  md_state_e       state_q;
  logic [CW-1:0]   cnt_q;
  logic            busy_q;

  // Reset abandons any in-flight operation at once.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= ST_RUN;
      cnt_q   <= CNT_ZERO;
      busy_q  <= 1'b0;
    end else begin
      case (state_q)
        ST_RUN: begin
          if (accept) begin
            state_q <= ST_BUSY;
            cnt_q   <= CNT_LOAD;
            busy_q  <= 1'b1;
          end else begin
            cnt_q   <= CNT_ZERO;
            busy_q  <= 1'b0;
          end
        end
        ST_BUSY: begin
          if (cnt_q == CNT_ONE) begin
            state_q <= ST_RUN;
            cnt_q   <= CNT_ZERO;
            busy_q  <= 1'b0;
          end else begin
            cnt_q   <= cnt_q - CNT_ONE;
            busy_q  <= 1'b1;
          end
        end
        default: begin
          state_q <= ST_RUN;
          cnt_q   <= CNT_ZERO;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign busy_o = busy_q;

endmodule

// File: rtl/hazard_controller.sv
// Pipeline hazard controller: load-use, branch-operand and HI/LO hazards
// drive the IF-stage enables/flushes and the ID/EX bubble.
module hazard_controller
  import hazard_pkg::*;
#(
  parameter int MULDIV_CYCLES = 32,
  parameter int CNT_W         = 32
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [REG_W-1:0] IDRs,
  input  logic [REG_W-1:0] IDRt,
  input  logic             IDUsesRs,
  input  logic             IDUsesRt,
  input  logic             IDIsBranch,
  input  logic             IDJump,
  input  logic             IDIsMulDiv,
  input  logic             IDUsesHiLo,
  input  logic             EXMemRead,
  input  logic             EXRegWrite,
  input  logic [REG_W-1:0] EXRd,
  input  logic             MEMMemRead,
  input  logic [REG_W-1:0] MEMRd,
  output logic             IFPCWrite,
  output logic             IFIDWrite,
  output logic             IFIDFlush,
  output logic             IDEXFlush,
  output logic             MulDivBusy,
  output logic [CNT_W-1:0] StallCycles
);

  logic             ex_hit;
  logic             mem_hit;
  logic             load_use;
  logic             branch_haz;
  logic             hilo_haz;
  logic             stall;
  logic             accept;
  logic [CNT_W-1:0] stall_cnt_d;
  logic [CNT_W-1:0] stall_cnt_q;

  assign ex_hit  = reg_match(IDUsesRs, IDRs, EXRd)  || reg_match(IDUsesRt, IDRt, EXRd);
  assign mem_hit = reg_match(IDUsesRs, IDRs, MEMRd) || reg_match(IDUsesRt, IDRt, MEMRd);

  assign load_use   = EXMemRead && ex_hit;
  assign branch_haz = IDIsBranch && ((EXRegWrite && ex_hit) || (MEMMemRead && mem_hit));
  assign hilo_haz   = MulDivBusy && (IDIsMulDiv || IDUsesHiLo);
  assign stall      = load_use || branch_haz || hilo_haz;
  assign accept     = IDIsMulDiv && !stall;

  muldiv_tracker #(
    .MULDIV_CYCLES(MULDIV_CYCLES)
  ) u_muldiv (
    .clock (clock),
    .reset (reset),
    .accept(accept),
    .busy_o(MulDivBusy)
  );

  // A stall overrides any redirect; the ID instruction is retried next cycle.
  always_comb begin
    IFPCWrite = 1'b1;
    IFIDWrite = 1'b1;
    IFIDFlush = 1'b0;
    IDEXFlush = 1'b0;
    if (reset) begin
      IFPCWrite = 1'b0;
      IFIDWrite = 1'b0;
      IFIDFlush = 1'b1;
      IDEXFlush = 1'b1;
    end else if (stall) begin
      IFPCWrite = 1'b0;
      IFIDWrite = 1'b0;
      IFIDFlush = 1'b0;
      IDEXFlush = 1'b1;
    end else begin
      IFIDFlush = IDJump;
    end
  end

  // Saturating count of stalled cycles.
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (stall && (stall_cnt_q != {CNT_W{1'b1}})) begin
      stall_cnt_d = stall_cnt_q + CNT_W'(1);
    end else begin
      stall_cnt_d = stall_cnt_q;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      stall_cnt_q <= {CNT_W{1'b0}};
    end else begin
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign StallCycles = stall_cnt_q;

endmodule

// File: tb/tb_hazard_controller.sv
// Directed, table-driven bench for hazard_controller (MULDIV_CYCLES=4, CNT_W=4).
module tb_hazard_controller;

  logic       clock;
  logic       reset;
  logic [4:0] IDRs, IDRt, EXRd, MEMRd;
  logic       IDUsesRs, IDUsesRt, IDIsBranch, IDJump, IDIsMulDiv, IDUsesHiLo;
  logic       EXMemRead, EXRegWrite, MEMMemRead;
  logic       IFPCWrite, IFIDWrite, IFIDFlush, IDEXFlush, MulDivBusy;
  logic [3:0] StallCycles;

  int n_cmp = 0;
  int n_err = 0;
  int exp_cnt = 0;

  hazard_controller #(.MULDIV_CYCLES(4), .CNT_W(4)) dut (
    .clock(clock), .reset(reset),
    .IDRs(IDRs), .IDRt(IDRt), .IDUsesRs(IDUsesRs), .IDUsesRt(IDUsesRt),
    .IDIsBranch(IDIsBranch), .IDJump(IDJump), .IDIsMulDiv(IDIsMulDiv),
    .IDUsesHiLo(IDUsesHiLo), .EXMemRead(EXMemRead), .EXRegWrite(EXRegWrite),
    .EXRd(EXRd), .MEMMemRead(MEMMemRead), .MEMRd(MEMRd),
    .IFPCWrite(IFPCWrite), .IFIDWrite(IFIDWrite), .IFIDFlush(IFIDFlush),
    .IDEXFlush(IDEXFlush), .MulDivBusy(MulDivBusy), .StallCycles(StallCycles)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    logic [4:0] rs; logic urs; logic [4:0] rt; logic urt;
    logic br; logic jmp; logic exmr; logic exrw; logic [4:0] exrd;
    logic memmr; logic [4:0] memrd;
    logic e_pcw; logic e_ifidf; logic e_idexf;
  } vec_t;

  vec_t vecs[12];

  function automatic vec_t mk(input logic [4:0] rs, input logic urs,
                              input logic [4:0] rt, input logic urt,
                              input logic br, input logic jmp,
                              input logic exmr, input logic exrw, input logic [4:0] exrd,
                              input logic memmr, input logic [4:0] memrd,
                              input logic e_pcw, input logic e_ifidf, input logic e_idexf);
    vec_t v;
    v.rs = rs; v.urs = urs; v.rt = rt; v.urt = urt; v.br = br; v.jmp = jmp;
    v.exmr = exmr; v.exrw = exrw; v.exrd = exrd; v.memmr = memmr; v.memrd = memrd;
    v.e_pcw = e_pcw; v.e_ifidf = e_ifidf; v.e_idexf = e_idexf;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic clear();
    IDRs = 5'd0; IDRt = 5'd0; IDUsesRs = 1'b0; IDUsesRt = 1'b0;
    IDIsBranch = 1'b0; IDJump = 1'b0; IDIsMulDiv = 1'b0; IDUsesHiLo = 1'b0;
    EXMemRead = 1'b0; EXRegWrite = 1'b0; EXRd = 5'd0;
    MEMMemRead = 1'b0; MEMRd = 5'd0;
  endtask

  task automatic drive(input vec_t v);
    clear();
    IDRs = v.rs; IDUsesRs = v.urs; IDRt = v.rt; IDUsesRt = v.urt;
    IDIsBranch = v.br; IDJump = v.jmp; EXMemRead = v.exmr; EXRegWrite = v.exrw;
    EXRd = v.exrd; MEMMemRead = v.memmr; MEMRd = v.memrd;
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic chk_ctl(input string nm, input logic pcw, input logic ifidf, input logic idexf);
    chk({nm, ".IFPCWrite"}, {31'd0, IFPCWrite}, {31'd0, pcw});
    chk({nm, ".IFIDWrite"}, {31'd0, IFIDWrite}, {31'd0, pcw});
    chk({nm, ".IFIDFlush"}, {31'd0, IFIDFlush}, {31'd0, ifidf});
    chk({nm, ".IDEXFlush"}, {31'd0, IDEXFlush}, {31'd0, idexf});
  endtask

  initial begin
    //           rs    urs   rt    urt   br    jmp   exmr  exrw  exrd   memmr memrd  pcw   ifidf idexf
    vecs[0]  = mk(5'd8, 1'b1, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 5'd8,  1'b0, 5'd0,  1'b0, 1'b0, 1'b1);
    vecs[1]  = mk(5'd0, 1'b1, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 5'd0,  1'b0, 5'd0,  1'b1, 1'b0, 1'b0);
    vecs[2]  = mk(5'd3, 1'b1, 5'd12,1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 5'd12, 1'b0, 5'd0,  1'b0, 1'b0, 1'b1);
    vecs[3]  = mk(5'd8, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 5'd8,  1'b0, 5'd0,  1'b1, 1'b0, 1'b0);
    vecs[4]  = mk(5'd8, 1'b1, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 5'd8,  1'b0, 5'd0,  1'b1, 1'b0, 1'b0);
    vecs[5]  = mk(5'd1, 1'b1, 5'd9, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 5'd9,  1'b0, 5'd0,  1'b0, 1'b0, 1'b1);
    vecs[6]  = mk(5'd10,1'b1, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 5'd0,  1'b1, 5'd10, 1'b0, 1'b0, 1'b1);
    vecs[7]  = mk(5'd10,1'b1, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0,  1'b1, 5'd10, 1'b1, 1'b0, 1'b0);
    vecs[8]  = mk(5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 5'd0,  1'b0, 5'd0,  1'b1, 1'b1, 1'b0);
    vecs[9]  = mk(5'd8, 1'b1, 5'd0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 5'd8,  1'b0, 5'd0,  1'b0, 1'b0, 1'b1);
    vecs[10] = mk(5'd4, 1'b1, 5'd0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 5'd0,  1'b1, 5'd0,  1'b1, 1'b0, 1'b0);
    vecs[11] = mk(5'd10,1'b1, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 5'd0,  1'b1, 5'd11, 1'b1, 1'b0, 1'b0);

    // Reset: outputs forced even with a live load-use hazard.
    reset = 1'b1;
    clear();
    IDRs = 5'd8; IDUsesRs = 1'b1; EXMemRead = 1'b1; EXRd = 5'd8;
    #2;
    chk_ctl("reset_forced", 1'b0, 1'b1, 1'b1);
    tick();
    tick();
    chk("reset_busy", {31'd0, MulDivBusy}, 32'd0);
    chk("reset_cnt", {28'd0, StallCycles}, 32'd0);
    reset = 1'b0;

    for (int i = 0; i < 12; i++) begin
      drive(vecs[i]);
      #4;
      chk_ctl($sformatf("vec%0d", i), vecs[i].e_pcw, vecs[i].e_ifidf, vecs[i].e_idexf);
      if (!vecs[i].e_pcw) exp_cnt++;
      tick();
      chk($sformatf("vec%0d.StallCycles", i), {28'd0, StallCycles}, exp_cnt);
    end

    // Branch after ALU producer: one stall, then a taken branch redirects.
    clear(); IDIsBranch = 1'b1; IDRt = 5'd9; IDUsesRt = 1'b1; EXRegWrite = 1'b1; EXRd = 5'd9;
    #4; chk_ctl("br_alu_c1", 1'b0, 1'b0, 1'b1); exp_cnt++; tick();
    EXRegWrite = 1'b0; EXRd = 5'd0; MEMRd = 5'd9; IDJump = 1'b1;
    #4; chk_ctl("br_alu_c2", 1'b1, 1'b1, 1'b0); tick();

    // Branch after load: two stall cycles, then free.
    clear(); IDIsBranch = 1'b1; IDRs = 5'd10; IDUsesRs = 1'b1;
    EXMemRead = 1'b1; EXRegWrite = 1'b1; EXRd = 5'd10;
    #4; chk_ctl("br_ld_c1", 1'b0, 1'b0, 1'b1); exp_cnt++; tick();
    EXMemRead = 1'b0; EXRegWrite = 1'b0; EXRd = 5'd0; MEMMemRead = 1'b1; MEMRd = 5'd10;
    #4; chk_ctl("br_ld_c2", 1'b0, 1'b0, 1'b1); exp_cnt++; tick();
    MEMMemRead = 1'b0; MEMRd = 5'd0;
    #4; chk_ctl("br_ld_c3", 1'b1, 1'b0, 1'b0); tick();

    // Jump during a load-use stall is deferred one cycle.
    clear(); IDJump = 1'b1; IDRs = 5'd8; IDUsesRs = 1'b1; EXMemRead = 1'b1; EXRd = 5'd8;
    #4; chk_ctl("jmp_stall_c1", 1'b0, 1'b0, 1'b1); exp_cnt++; tick();
    EXMemRead = 1'b0; EXRd = 5'd0;
    #4; chk_ctl("jmp_stall_c2", 1'b1, 1'b1, 1'b0); tick();
    chk("pre_md.StallCycles", {28'd0, StallCycles}, exp_cnt);

    // Mult accepted at edge 0; HI/LO read, then a second mult, wait for RUN.
    clear(); IDIsMulDiv = 1'b1;
    #4; chk_ctl("md_c0", 1'b1, 1'b0, 1'b0); chk("md_c0.busy", {31'd0, MulDivBusy}, 32'd0); tick();
    IDIsMulDiv = 1'b0; IDUsesHiLo = 1'b1;
    #4; chk_ctl("md_c1", 1'b0, 1'b0, 1'b1); chk("md_c1.busy", {31'd0, MulDivBusy}, 32'd1); tick();
    IDUsesHiLo = 1'b0; IDIsMulDiv = 1'b1;
    #4; chk_ctl("md_c2", 1'b0, 1'b0, 1'b1); chk("md_c2.busy", {31'd0, MulDivBusy}, 32'd1); tick();
    #4; chk_ctl("md_c3", 1'b0, 1'b0, 1'b1); chk("md_c3.busy", {31'd0, MulDivBusy}, 32'd1); tick();
    #4; chk_ctl("md_c4", 1'b1, 1'b0, 1'b0); chk("md_c4.busy", {31'd0, MulDivBusy}, 32'd0); tick();
    exp_cnt += 3;
    IDIsMulDiv = 1'b0; IDUsesHiLo = 1'b1;
    #4; chk_ctl("md_c5", 1'b0, 1'b0, 1'b1); chk("md_c5.busy", {31'd0, MulDivBusy}, 32'd1);
    chk("md_c5.StallCycles", {28'd0, StallCycles}, exp_cnt); tick();

    // Reset in cycle 2 of the second operation abandons it.
    reset = 1'b1; IDJump = 1'b1;
    #4; chk_ctl("md_rst", 1'b0, 1'b1, 1'b1); tick();
    chk("md_rst.busy", {31'd0, MulDivBusy}, 32'd0);
    chk("md_rst.StallCycles", {28'd0, StallCycles}, 32'd0);
    reset = 1'b0; IDJump = 1'b0; exp_cnt = 0;
    #4; chk_ctl("md_post_rst", 1'b1, 1'b0, 1'b0); tick();
    chk("md_post_rst.busy", {31'd0, MulDivBusy}, 32'd0);

    // Counter saturates at all-ones instead of wrapping.
    clear(); IDRt = 5'd5; IDUsesRt = 1'b1; EXMemRead = 1'b1; EXRd = 5'd5;
    for (int i = 0; i < 18; i++) begin
      tick();
      if (i == 13) chk("sat_14", {28'd0, StallCycles}, 32'd14);
    end
    chk("sat_hold", {28'd0, StallCycles}, 32'd15);
    clear();
    tick();
    chk("sat_idle", {28'd0, StallCycles}, 32'd15);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/hazard_controller.md
# hazard_controller

Pipeline control unit for the 5-stage core: it decides each cycle whether the IF stage advances, holds or is redirected. It detects load-use and branch-operand hazards in ID and tracks the multi-cycle multiply/divide unit. From these it drives the IF-stage controls `IFPCWrite`, `IFIDWrite` and `IFIDFlush`, plus the ID/EX bubble control `IDEXFlush`. It sits beside the ID stage and is the only source of those four signals.

## Interface
- `MULDIV_CYCLES`, 32: EX-occupancy of one mult/div op in cycles (≥2).
- `CNT_W`, 32: width of the stall performance counter.

Ports:
- `clock`  in  1  single clock; all state updates on rising edge.
- `reset`  in  1  synchronous, active-high.
- `IDRs`, `IDRt`  in  5 each  source register numbers of the instruction in ID.
- `IDUsesRs`, `IDUsesRt`  in  1 each  ID instruction reads that operand.
- `IDIsBranch`  in  1  conditional branch resolved in ID; needs operands in ID.
- `IDJump`  in  1  ID redirects fetch (jump or taken branch).
- `IDIsMulDiv`  in  1  ID instruction is mult/multu/div/divu.
- `IDUsesHiLo`  in  1  ID instruction is mfhi/mflo/mthi/mtlo.
- `EXMemRead`, `EXRegWrite`  in  1 each  EX-stage instruction properties.
- `EXRd`  in  5  EX-stage destination register.
- `MEMMemRead`  in  1  MEM-stage instruction is a load.
- `MEMRd`  in  5  MEM-stage destination register.
- `IFPCWrite`  out  1  PC register enable.
- `IFIDWrite`  out  1  IF/ID register enable.
- `IFIDFlush`  out  1  zero IF/ID on next edge.
- `IDEXFlush`  out  1  insert bubble into ID/EX on next edge.
- `MulDivBusy`  out  1  mult/div unit occupied.
- `StallCycles`  out  `CNT_W`  count of cycles with `IFPCWrite`=0.

## Operation
- Match functions:
  - `rs_hit(r)` = `IDUsesRs` && r!=0 && r==`IDRs`.
  - `rt_hit(r)` is the same test against `IDRt`.
  - `hit(r)` = `rs_hit(r)` || `rt_hit(r)`.
- Load-use hazard: `EXMemRead` && `hit(EXRd)`.
- Branch hazard: `IDIsBranch` && ((`EXRegWrite` && `hit(EXRd)`) || (`MEMMemRead` && `hit(MEMRd)`)).
- HI/LO hazard: state BUSY && (`IDIsMulDiv` || `IDUsesHiLo`).
- `stall` = OR of the three hazards.
- When `stall` is 1:
  - `IFPCWrite`=0, `IFIDWrite`=0, `IDEXFlush`=1, `IFIDFlush`=0.
  - `IDJump` is ignored; the ID instruction is re-evaluated next cycle.
- When `stall` is 0: `IFPCWrite`=1, `IFIDWrite`=1, `IDEXFlush`=0, `IFIDFlush`=`IDJump`.
- FSM has two states, RUN and BUSY, with down-counter `cnt` of width clog2(`MULDIV_CYCLES`).
  - RUN → BUSY when `IDIsMulDiv` && !`stall`; load `cnt`=`MULDIV_CYCLES`-1.
  - BUSY: `cnt` decrements each cycle. BUSY → RUN on the edge where `cnt`==1; `cnt`=0 in RUN.
  - `MulDivBusy` = (state==BUSY).
- `StallCycles` increments on each edge where `IFPCWrite`=0 and `reset`=0. It saturates at all-ones and never wraps.

## Timing
- Control outputs are combinational from inputs and registered state, valid the same cycle. They take effect on the next `clock` edge.
- A load-use stall lasts exactly 1 cycle.
- A branch stall lasts 1 cycle if the producer is an ALU op in EX. It lasts 2 cycles if the producer is a load in EX: the load-use stall, then the MEM-load branch stall.
- A mult/div accepted at edge N leaves BUSY at edge N+`MULDIV_CYCLES`-1. A dependent HI/LO access in ID is released in the first RUN cycle.
- Reset (sampled high at an edge): state=RUN, `cnt`=0, `StallCycles`=0, `MulDivBusy`=0.
- While `reset` is high, outputs are forced regardless of inputs: `IFPCWrite`=0, `IFIDWrite`=0, `IFIDFlush`=1, `IDEXFlush`=1.
- Reset mid-BUSY abandons the operation immediately.
- Simultaneous events:
  - Stall plus `IDJump`: the stall wins.
  - BUSY plus a new `IDIsMulDiv`: stall until RUN, then accept.
  - A `$0` destination never causes a hazard.

## Structure
- Shared package `hazard_pkg` holds:
  - state encoding (RUN, BUSY);
  - `REG_ZERO`=5'd0;
  - register-number width 5.
- One sub-module, `muldiv_tracker`, holds the FSM, `cnt` and `MulDivBusy`. Its inputs are `accept`=`IDIsMulDiv`&&!`stall` and `reset`.
- Hazard compare and output muxing stay in the top level.

## Test plan
- Load-use: `EXMemRead`=1, `EXRd`=8, `IDUsesRs`=1, `IDRs`=8.
  - Required: 1 cycle with `IFPCWrite`=0, `IFIDWrite`=0, `IDEXFlush`=1; `StallCycles` becomes 1.
  - Repeat with `EXRd`=0: no stall.
- Branch after ALU op: `IDIsBranch`=1, `EXRegWrite`=1, `EXRd`=9=`IDRt`.
  - Required: 1 stall cycle, then the next cycle with `IDJump`=1 gives `IFIDFlush`=1, `IFPCWrite`=1.
- Branch after load: load writing `$10` in EX, then in MEM, branch reads `$10`.
  - Required: exactly 2 stall cycles, then no stall.
- Jump during stall: `IDJump`=1 with a load-use hazard active.
  - Required: `IFIDFlush`=0 that cycle; `IFIDFlush`=1 the following cycle once the hazard clears.
- Mult/div: `MULDIV_CYCLES`=4, mult accepted at edge 0, `IDUsesHiLo`=1 from cycle 1.
  - Required: `MulDivBusy`=1 for cycles 1–3; stall in cycles 1–3; release in cycle 4.
  - A second mult in cycle 2 also stalls until RUN.
- Reset mid-BUSY: assert `reset` at cycle 2 of 32.
  - Required: next cycle `MulDivBusy`=0 and `StallCycles`=0. While `reset` is high, `IFIDFlush`=1 and `IDEXFlush`=1.
